hwt_nibble_rx: RTL and testbench

Serial-to-parallel front end that sits directly upstream of the hwt combinational decision block. It receives framed serial bits, checks parity, and drives the hwt inputs A, B, C and D as registered, stable levels. A valid/ready handshake presents each nibble. Overrun and parity errors are flagged, and accepted nibbles are counted.

---
 rtl/hwt_nibble_rx.sv | 119 +++++++++++
 tb/tb_hwt_nibble_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwt_nibble_rx.sv
// Serial-to-parallel receiver feeding the hwt decision block: frames four data bits
// (A first), optionally checks even parity, and presents a registered nibble over valid/ready.
module hwt_nibble_rx #(
  parameter bit PARITY_EN = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             out_ready,
  input  logic             clr_flags,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             out_valid,
  output logic             perr,
  output logic             ovr,
  output logic [CNT_W-1:0] nib_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] shift_q, shift_d;    // shift_q[0] holds bit A
  logic [3:0] nib_q;               // same layout as shift_q
  logic       commit;
  logic       perr_set;
  logic       ovr_set;
  logic       xfer;
  logic [3:0] commit_nib;

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    commit     = 1'b0;
    perr_set   = 1'b0;
    commit_nib = shift_q;
    if (frame_start) begin
      // A strobe coincident with frame_start is already data bit A of the new frame.
      state_d = DATA;
      idx_d   = 2'd0;
      if (sin_valid) begin
        shift_d[0] = sin;
        idx_d      = 2'd1;
      end
    end else if (sin_valid) begin
      case (state_q)
        DATA: begin
          shift_d[idx_q] = sin;
          idx_d          = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            if (PARITY_EN) begin
              state_d = PAR;
            end else begin
              state_d    = IDLE;
              commit     = 1'b1;
              commit_nib = shift_d;
            end
          end
        end
        PAR: begin
          state_d = IDLE;
          if (^{shift_q, sin}) perr_set = 1'b1;
          else                 commit   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign xfer    = out_valid & out_ready;
  assign ovr_set = commit & out_valid & ~out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      shift_q <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_q     <= 4'd0;
      out_valid <= 1'b0;
      perr      <= 1'b0;
      ovr       <= 1'b0;
      nib_cnt   <= '0;
    end else begin
      // A held nibble is never overwritten; a commit only lands when the slot is free or draining.
      if (commit && (!out_valid || out_ready)) begin
        nib_q     <= commit_nib;
        out_valid <= 1'b1;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
      if (xfer) nib_cnt <= nib_cnt + 1'b1;
      perr <= perr_set | (perr & ~clr_flags);
      ovr  <= ovr_set  | (ovr  & ~clr_flags);
    end
  end

  assign a = nib_q[0];
  assign b = nib_q[1];
  assign c = nib_q[2];
  assign d = nib_q[3];

endmodule

// File: tb/tb_hwt_nibble_rx.sv
// Bench for hwt_nibble_rx: a parity and a no-parity instance share stimulus and are compared
// every cycle against a frame-level model, plus literal expectations for directed scenarios.
module tb_hwt_nibble_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0, sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;

  logic p_a, p_b, p_c, p_d, p_valid, p_perr, p_ovr;
  logic [1:0] p_cnt;
  logic n_a, n_b, n_c, n_d, n_valid, n_perr, n_ovr;
  logic [7:0] n_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hwt_nibble_rx #(.PARITY_EN(1'b1), .CNT_W(2)) u_p (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sin(sin), .sin_valid(sin_valid),
    .out_ready(out_ready), .clr_flags(clr_flags), .a(p_a), .b(p_b), .c(p_c), .d(p_d),
    .out_valid(p_valid), .perr(p_perr), .ovr(p_ovr), .nib_cnt(p_cnt));

  hwt_nibble_rx #(.PARITY_EN(1'b0), .CNT_W(8)) u_n (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sin(sin), .sin_valid(sin_valid),
    .out_ready(out_ready), .clr_flags(clr_flags), .a(n_a), .b(n_b), .c(n_c), .d(n_d),
    .out_valid(n_valid), .perr(n_perr), .ovr(n_ovr), .nib_cnt(n_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: index 0 = parity instance (5-bit frames, counter mod 4), index 1 = no parity (4-bit, mod 256).
  // Received bits are collected in arrival order; the nibble is kept as {A,B,C,D}.
  bit         m_in[2];
  int         m_n[2];
  logic [4:0] m_w[2];
  logic [3:0] m_nib[2];
  bit         m_valid[2], m_perr[2], m_ovr[2];
  int         m_cnt[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_in[i] = 0; m_n[i] = 0; m_w[i] = '0; m_nib[i] = '0;
      m_valid[i] = 0; m_perr[i] = 0; m_ovr[i] = 0; m_cnt[i] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] nib;
    bit commit, perr_ev, ovr_ev, xfer;
    int need;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_in[i] = 0; m_n[i] = 0; m_w[i] = '0; m_nib[i] = '0;
        m_valid[i] = 0; m_perr[i] = 0; m_ovr[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        need    = (i == 0) ? 5 : 4;
        commit  = 0;
        perr_ev = 0;
        ovr_ev  = 0;
        nib     = '0;
        xfer    = m_valid[i] && out_ready;
        if (frame_start) begin
          m_in[i] = 1; m_n[i] = 0; m_w[i] = '0;
        end
        if (m_in[i] && sin_valid) begin
          m_w[i][m_n[i]] = sin;
          m_n[i]++;
        end
        if (m_in[i] && m_n[i] == need) begin
          m_in[i] = 0;
          nib = {m_w[i][0], m_w[i][1], m_w[i][2], m_w[i][3]};
          if (need == 5 && (^m_w[i])) perr_ev = 1;
          else                        commit  = 1;
        end
        if (xfer) m_cnt[i] = (m_cnt[i] + 1) % ((i == 0) ? 4 : 256);
        if (commit && m_valid[i] && !out_ready) ovr_ev = 1;
        else if (commit) begin m_nib[i] = nib; m_valid[i] = 1; end
        else if (xfer) m_valid[i] = 0;
        m_perr[i] = perr_ev || (m_perr[i] && !clr_flags);
        m_ovr[i]  = ovr_ev  || (m_ovr[i]  && !clr_flags);
      end
    end
  end

  always @(negedge clk) begin
    check("p_abcd",  32'({p_a, p_b, p_c, p_d}), 32'(m_nib[0]));
    check("p_valid", 32'(p_valid), 32'(m_valid[0]));
    check("p_perr",  32'(p_perr),  32'(m_perr[0]));
    check("p_ovr",   32'(p_ovr),   32'(m_ovr[0]));
    check("p_cnt",   32'(p_cnt),   m_cnt[0]);
    check("n_abcd",  32'({n_a, n_b, n_c, n_d}), 32'(m_nib[1]));
    check("n_valid", 32'(n_valid), 32'(m_valid[1]));
    check("n_perr",  32'(n_perr),  32'(m_perr[1]));
    check("n_ovr",   32'(n_ovr),   32'(m_ovr[1]));
    check("n_cnt",   32'(n_cnt),   m_cnt[1]);
  end

  task automatic cyc(input bit fs, input bit sv, input bit s, input bit rdy, input bit clr);
    frame_start = fs; sin_valid = sv; sin = s; out_ready = rdy; clr_flags = clr;
    @(posedge clk);
    #1;
  endtask

  // abcd is written as read left to right: abcd[3] is A, sent first.
  task automatic frame(input logic [3:0] abcd, input bit bad, input bit last_rdy, input bit last_clr);
    cyc(1, 0, 0, 0, 0);
    for (int k = 3; k >= 0; k--) cyc(0, 1, abcd[k], 0, 0);
    cyc(0, 1, (^abcd) ^ bad, last_rdy, last_clr);
  endtask

  task automatic drain();
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic pin_p(input string name, input logic [3:0] abcd, input bit v, input logic [1:0] cnt);
    check({name, "_abcd"},  32'({p_a, p_b, p_c, p_d}), 32'(abcd));
    check({name, "_valid"}, 32'(p_valid), 32'(v));
    check({name, "_cnt"},   32'(p_cnt),   32'(cnt));
    check({name, "_model"}, 32'({m_nib[0], m_valid[0], 2'(m_cnt[0])}), 32'({abcd, v, cnt}));
  endtask

  initial begin
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    pin_p("reset", 4'b0000, 1'b0, 2'd0);

    // Reset mid-frame, then a clean frame.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_outs", 32'({p_a, p_b, p_c, p_d, p_valid, p_perr, p_ovr, p_cnt}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0);
    frame(4'b1101, 0, 0, 0);
    pin_p("after_rst", 4'b1101, 1'b1, 2'd0);
    drain();
    pin_p("after_rst_xfer", 4'b1101, 1'b0, 2'd1);

    // Good frame.
    frame(4'b1110, 0, 0, 0);
    pin_p("good", 4'b1110, 1'b1, 2'd1);
    drain();
    pin_p("good_xfer", 4'b1110, 1'b0, 2'd2);

    // Parity error, clear, then clear colliding with a new error.
    frame(4'b1000, 1, 0, 0);
    check("perr_set", 32'(p_perr), 32'd1);
    pin_p("perr", 4'b1110, 1'b0, 2'd2);
    cyc(0, 0, 0, 0, 1);
    check("perr_clr", 32'(p_perr), 32'd0);
    frame(4'b1000, 1, 0, 1);
    check("perr_set_wins", 32'(p_perr), 32'd1);
    cyc(0, 0, 0, 0, 1);
    check("perr_clr2", 32'(p_perr), 32'd0);

    // Overrun.
    frame(4'b0011, 0, 0, 0);
    frame(4'b0101, 0, 0, 0);
    check("ovr_set", 32'(p_ovr), 32'd1);
    pin_p("ovr", 4'b0011, 1'b1, 2'd2);
    drain();
    pin_p("ovr_xfer", 4'b0011, 1'b0, 2'd3);
    cyc(0, 0, 0, 0, 1);
    check("ovr_clr", 32'(p_ovr), 32'd0);

    // Back-to-back: second commit lands on the transfer edge of the first.
    frame(4'b1100, 0, 0, 0);
    pin_p("b2b_first", 4'b1100, 1'b1, 2'd3);
    frame(4'b0011, 0, 1, 0);
    check("b2b_ovr", 32'(p_ovr), 32'd0);
    pin_p("b2b_second", 4'b0011, 1'b1, 2'd0);
    drain();
    pin_p("wrap", 4'b0011, 1'b0, 2'd1);

    // Abort after two bits, then a full frame.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    frame(4'b0110, 0, 0, 0);
    pin_p("abort", 4'b0110, 1'b1, 2'd1);
    drain();

    // frame_start with a coincident strobe: that bit is A.
    cyc(1, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    pin_p("fs_sv", 4'b1010, 1'b1, 2'd2);
    drain();

    // Randomized mix of well-formed frames and free-running noise.
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0)
        frame(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      for (int j = 0; j < int'($urandom_range(1, 6)); j++)
        cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 11) == 0));
    end
    drain();
    cyc(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
